sp_class_composer: RTL and testbench

// Inverse of the single-precision classifier. Takes a 10-bit one-hot class code (fclass
// bit order) plus a 31-bit seed, and builds an IEEE-754 binary32 value of exactly that class.

---
 rtl/sp_class_pkg.sv | 39 +++
 rtl/sp_class_composer_onehot.sv | 12 +
 rtl/sp_class_composer.sv | 116 +++++++++++
 tb/tb_sp_class_composer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_class_pkg.sv
// Shared definitions for the binary32 class composer.
// Class bit positions follow the fclass result ordering.
package sp_class_pkg;

    localparam int CLS_NINF  = 0;
    localparam int CLS_NNORM = 1;
    localparam int CLS_NSUB  = 2;
    localparam int CLS_NZERO = 3;
    localparam int CLS_PZERO = 4;
    localparam int CLS_PSUB  = 5;
    localparam int CLS_PNORM = 6;
    localparam int CLS_PINF  = 7;
    localparam int CLS_SNAN  = 8;
    localparam int CLS_QNAN  = 9;

    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        BUILD = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Keep a normal exponent away from the zero/subnormal and inf/NaN codes.
    function automatic logic [7:0] clamp_norm_exp(input logic [7:0] e);
        if (e == 8'h00)
            return 8'h01;
        else if (e == EXP_MAX)
            return 8'hFE;
        else
            return e;
    endfunction

endpackage

// File: rtl/sp_class_composer_onehot.sv
// Combinational test that a class code has exactly one bit set.
// Zero bits set is not one-hot.
module sp_onehot_check (
    input  logic [9:0] vec,
    output logic       is_onehot
);

    always_comb begin
        is_onehot = (vec != 10'd0) && ((vec & (vec - 10'd1)) == 10'd0);
    end

endmodule

// File: rtl/sp_class_composer.sv
// Builds a binary32 value of a requested fclass category from a seed.
// Four-state start/busy/done sequence; the result is held until the next start.
module sp_class_composer
    import sp_class_pkg::*;
#(
    parameter bit          NAN_PAYLOAD = 1'b1,
    parameter logic [31:0] CANON_NAN   = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  class_in,
    input  logic [30:0] seed,
    output logic [31:0] fp_out,
    output logic        err,
    output logic        busy,
    output logic        done
);

    state_t      state;
    state_t      state_nx;
    logic [9:0]  cls_q;
    logic [30:0] seed_q;
    logic        onehot;
    logic        onehot_q;
    logic        sign;
    logic [7:0]  exp_f;
    logic [22:0] man_f;
    logic [21:0] pay;
    logic [31:0] word;

    sp_onehot_check u_chk (
        .vec       (cls_q),
        .is_onehot (onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        unique case (state)
            IDLE:    if (start) state_nx = CHECK;
            CHECK:   state_nx = BUILD;
            BUILD:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_q    <= '0;
            seed_q   <= '0;
            onehot_q <= 1'b0;
            fp_out   <= POS_ZERO;
            err      <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cls_q  <= class_in;
                seed_q <= seed;
            end
            if (state == CHECK)
                onehot_q <= onehot;
            if (state == BUILD) begin
                fp_out <= onehot_q ? word : CANON_NAN;
                err    <= ~onehot_q;
            end
        end
    end

    // The decode runs only for a valid code, so exactly one arm can match.
    always_comb begin
        sign  = |cls_q[CLS_NZERO:CLS_NINF];
        exp_f = 8'h00;
        man_f = 23'h0;
        pay   = NAN_PAYLOAD ? seed_q[21:0] : 22'h0;
        if (onehot) begin
            unique case (1'b1)
                cls_q[CLS_NINF], cls_q[CLS_PINF]: begin
                    exp_f = EXP_MAX;
                end
                cls_q[CLS_NNORM], cls_q[CLS_PNORM]: begin
                    exp_f = clamp_norm_exp(seed_q[30:23]);
                    man_f = seed_q[22:0];
                end
                cls_q[CLS_NSUB], cls_q[CLS_PSUB]: begin
                    man_f = (seed_q[22:0] == 23'h0) ? 23'h1
                                                    : seed_q[22:0];
                end
                cls_q[CLS_NZERO], cls_q[CLS_PZERO]: begin
                    exp_f = 8'h00;
                end
                cls_q[CLS_SNAN]: begin
                    exp_f = EXP_MAX;
                    man_f = {1'b0, (pay == 22'h0) ? 22'h1 : pay};
                end
                cls_q[CLS_QNAN]: begin
                    exp_f = EXP_MAX;
                    man_f = {1'b1, pay};
                end
                default: begin
                    exp_f = 8'h00;
                end
            endcase
        end
        word = {sign, exp_f, man_f};
    end

endmodule

// File: tb/tb_sp_class_composer.sv
// Bench for sp_class_composer: vector table, corner sequences and a random
// sweep checked against an arithmetic model and an fclass-style classifier.
module tb_sp_class_composer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  class_in;
    logic [30:0] seed;
    logic [31:0] fp1, fp0;
    logic        err1, err0, busy1, busy0, done1, done0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sp_class_composer #(.NAN_PAYLOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .class_in(class_in),
        .seed(seed), .fp_out(fp1), .err(err1), .busy(busy1), .done(done1)
    );

    sp_class_composer #(.NAN_PAYLOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .class_in(class_in),
        .seed(seed), .fp_out(fp0), .err(err0), .busy(busy0), .done(done0)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [9:0] c,
                                          input logic [30:0] s,
                                          input bit p);
        int          idx;
        logic        sg;
        logic [7:0]  e;
        logic [22:0] m;
        if ($countones(c) != 1)
            return 32'h7FC0_0000;
        idx = 0;
        for (int i = 0; i < 10; i++)
            if (c[i]) idx = i;
        sg = (idx <= 3);
        e  = s[30:23];
        m  = s[22:0];
        case (idx)
            0, 7: return {sg, 8'hFF, 23'd0};
            3, 4: return {sg, 31'd0};
            1, 6: begin
                if (e == 8'd0) e = 8'd1;
                else if (e == 8'd255) e = 8'd254;
                return {sg, e, m};
            end
            2, 5: begin
                if (m == 23'd0) m = 23'd1;
                return {sg, 8'd0, m};
            end
            8: begin
                m = p ? {1'b0, s[21:0]} : 23'd0;
                if (m == 23'd0) m = 23'd1;
                return {1'b0, 8'hFF, m};
            end
            default: begin
                m = p ? {1'b1, s[21:0]} : 23'h40_0000;
                return {1'b0, 8'hFF, m};
            end
        endcase
    endfunction

    function automatic logic [9:0] classify(input logic [31:0] x);
        logic        sg;
        logic [7:0]  e;
        logic [22:0] m;
        int          idx;
        sg = x[31];
        e  = x[30:23];
        m  = x[22:0];
        if (e == 8'hFF) begin
            if (m == 23'd0) idx = sg ? 0 : 7;
            else idx = m[22] ? 9 : 8;
        end else if (e == 8'd0) begin
            if (m == 23'd0) idx = sg ? 3 : 4;
            else idx = sg ? 2 : 5;
        end else begin
            idx = sg ? 1 : 6;
        end
        return 10'd1 << idx;
    endfunction

    // One transaction: checks latency, busy and the single-cycle done.
    task automatic run_op(input logic [9:0] c, input logic [30:0] s,
                          output logic [31:0] f1, output logic [31:0] f0,
                          output logic e1, output logic e0);
        int lat;
        @(negedge clk);
        start    = 1'b1;
        class_in = c;
        seed     = s;
        @(posedge clk);
        #1;
        start    = 1'b0;
        class_in = 10'($urandom);
        seed     = 31'($urandom);
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_after_accept", 32'(busy1), 32'd1);
            if (done1) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd2);
        chk("done_pair", 32'(done0), 32'(done1));
        f1 = fp1;
        f0 = fp0;
        e1 = err1;
        e0 = err0;
        @(negedge clk);
        chk("done_single", 32'(done1), 32'd0);
        chk("busy_idle", 32'(busy1), 32'd0);
    endtask

    typedef struct {
        logic [9:0]  c;
        logic [30:0] s;
        logic [31:0] f1;
        logic [31:0] f0;
        logic        e;
    } vec_t;

    vec_t        vt[$];
    logic [31:0] r1, r0;
    logic        q1, q0;
    logic [9:0]  rc;
    logic [30:0] rs;
    int          dcnt;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        class_in = '0;
        seed     = '0;

        vt.push_back('{10'h080, 31'h1234_5678, 32'h7F80_0000, 32'h7F80_0000, 1'b0});
        vt.push_back('{10'h001, 31'h0,         32'hFF80_0000, 32'hFF80_0000, 1'b0});
        vt.push_back('{10'h040, 31'h7F80_0000, 32'h7F00_0000, 32'h7F00_0000, 1'b0});
        vt.push_back('{10'h040, 31'h0,         32'h0080_0000, 32'h0080_0000, 1'b0});
        vt.push_back('{10'h004, 31'h0,         32'h8000_0001, 32'h8000_0001, 1'b0});
        vt.push_back('{10'h100, 31'h0,         32'h7F80_0001, 32'h7F80_0001, 1'b0});
        vt.push_back('{10'h200, 31'h15,        32'h7FC0_0015, 32'h7FC0_0000, 1'b0});
        vt.push_back('{10'h000, 31'h0,         32'h7FC0_0000, 32'h7FC0_0000, 1'b1});
        vt.push_back('{10'h041, 31'h0,         32'h7FC0_0000, 32'h7FC0_0000, 1'b1});
        vt.push_back('{10'h008, 31'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0});
        vt.push_back('{10'h010, 31'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vt.push_back('{10'h020, 31'h0001_2345, 32'h0001_2345, 32'h0001_2345, 1'b0});
        vt.push_back('{10'h002, 31'h407F_FFFF, 32'hC07F_FFFF, 32'hC07F_FFFF, 1'b0});
        vt.push_back('{10'h100, 31'h0040_0000, 32'h7F80_0001, 32'h7F80_0001, 1'b0});
        vt.push_back('{10'h100, 31'h0000_0abc, 32'h7F80_0abc, 32'h7F80_0001, 1'b0});

        #1;
        chk("reset_fp", fp1, 32'h0);
        chk("reset_err", 32'(err1), 32'd0);
        chk("reset_busy", 32'(busy1), 32'd0);
        chk("reset_done", 32'(done1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            run_op(vt[i].c, vt[i].s, r1, r0, q1, q0);
            chk($sformatf("vec%0d_fp", i), r1, vt[i].f1);
            chk($sformatf("vec%0d_fp_nopay", i), r0, vt[i].f0);
            chk($sformatf("vec%0d_err", i), 32'(q1), 32'(vt[i].e));
        end

        // Output must hold across idle cycles with inputs wiggling.
        repeat (3) begin
            @(negedge clk);
            class_in = 10'($urandom);
            seed     = 31'($urandom);
        end
        chk("hold_fp", fp1, 32'h7F80_0abc);

        for (int n = 0; n < 60; n++) begin
            if (n % 10 == 9)
                rc = 10'($urandom);
            else
                rc = 10'd1 << $urandom_range(9, 0);
            rs = 31'($urandom);
            run_op(rc, rs, r1, r0, q1, q0);
            chk($sformatf("rnd%0d_fp", n), r1, model(rc, rs, 1'b1));
            chk($sformatf("rnd%0d_fp_nopay", n), r0, model(rc, rs, 1'b0));
            chk($sformatf("rnd%0d_err", n), 32'(q1),
                32'($countones(rc) != 1));
            if ($countones(rc) == 1)
                chk($sformatf("rnd%0d_class", n), 32'(classify(r1)), 32'(rc));
        end

        // Reset asserted while the word is being assembled.
        run_op(10'h080, 31'h0, r1, r0, q1, q0);
        @(negedge clk);
        start    = 1'b1;
        class_in = 10'h040;
        seed     = 31'h1234_5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_fp", fp1, 32'h0);
        chk("rst_mid_busy", 32'(busy1), 32'd0);
        chk("rst_mid_done", 32'(done1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(10'h200, 31'h15, r1, r0, q1, q0);
        chk("post_rst_fp", r1, 32'h7FC0_0015);

        // Start held for ten edges: accepts at 0, 4 and 8 only.
        @(negedge clk);
        start    = 1'b1;
        class_in = 10'h080;
        seed     = 31'h0;
        dcnt     = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) start = 1'b0;
            @(negedge clk);
            if (done1) dcnt++;
        end
        chk("held_start_dones", 32'(dcnt), 32'd3);
        chk("held_start_fp", fp1, 32'h7F80_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
